kdtree_load_ctrl: RTL and testbench
===================================

// Module: kdtree_load_ctrl
// PURPOSE
//  Input-side load sequencer between the input FIFO (io->core, read side) and the KD-tree storage.
//  After a load_kdtree pulse, drains the FIFO word by word and assembles items in this order:
//    internal nodes (2 words each) -> leaf patches (6 words each) -> query patches (5 words each).
//  Issues one write per completed item to the node, leaf or query memory; asserts load_done when all are written.
// PARAMETERS
//  DATA_WIDTH   11   FIFO word width / patch element width
//  IDX_WIDTH    9    original-image patch index width (leaf patches only)
//  PATCH_SIZE   5    data words per patch
//  LEAF_SIZE    8    patches per leaf
//  NUM_LEAVES   64   leaves; NUM_NODES = NUM_LEAVES-1 (localparam)
//  NUM_QUERYS   494  query patches (ROW_SIZE*COL_SIZE = 26*19)
//  LEAF_ADDRW   6    $clog2(NUM_LEAVES); node address uses the same width
//  QUERY_ADDRW  9    $clog2(NUM_QUERYS)
// PORTS
//  clk            in   1                    core clock; sole clock
//  rst            in   1                    async reset, active-high
//  load_kdtree    in   1                    1-cycle start pulse
//  in_fifo_rdata  in   DATA_WIDTH           FIFO head word; valid while in_fifo_rempty_n=1
//  in_fifo_rempty_n in 1                    FIFO non-empty
//  in_fifo_deq    out  1                    pop head (combinational: busy & in_fifo_rempty_n)
//  node_wen       out  1                    node write strobe
//  node_waddr     out  LEAF_ADDRW           node number 0..NUM_NODES-1
//  node_wdim      out  DATA_WIDTH           word 0 of node (split dimension index)
//  node_wmedian   out  DATA_WIDTH           word 1 of node (median)
//  leaf_wen       out  1                    leaf-patch write strobe
//  leaf_waddr     out  LEAF_ADDRW           leaf number
//  leaf_wslot     out  $clog2(LEAF_SIZE)    patch slot within leaf
//  leaf_wpatch    out  PATCH_SIZE*DATA_WIDTH  word0 in [DATA_WIDTH-1:0]
//  leaf_widx      out  IDX_WIDTH            6th word, low IDX_WIDTH bits
//  query_wen      out  1                    query write strobe
//  query_waddr    out  QUERY_ADDRW          query number
//  query_wpatch   out  PATCH_SIZE*DATA_WIDTH  same packing as leaf_wpatch
//  busy           out  1                    state is NODES, LEAVES or QUERIES
//  load_done      out  1                    level; set entering DONE
//  load_err       out  1                    1-cycle pulse: load_kdtree rejected while busy
// BEHAVIOUR
//  FSM: IDLE -load_kdtree-> NODES -> LEAVES -> QUERIES -> DONE -load_kdtree-> NODES.
//    NODES->LEAVES on the last word of node NUM_NODES-1.
//    LEAVES->QUERIES on the 6th word of leaf NUM_LEAVES-1, slot LEAF_SIZE-1.
//    QUERIES->DONE on the 5th word of query NUM_QUERYS-1.
//  Word accepted in a cycle when in_fifo_deq=1; no acceptance in IDLE/DONE, so the FIFO is left untouched there.
//  FIFO stalls (rempty_n=0) pause assembly indefinitely; counters hold.
//  Counters: word_cnt within item; item counter, plus slot counter in LEAVES.
//    Slot wraps LEAF_SIZE-1 -> 0 and increments the leaf number.
//  Write strobes are registered: wen high exactly 1 cycle, the cycle after the item's last word is accepted.
//    Addr/data outputs are held until the next write of that type.
//    The node/leaf/query write streams are mutually exclusive in time.
//  Latency: last FIFO word of the load -> query_wen next cycle; load_done rises the same cycle as the final query_wen.
//  load_done clears on an accepted load_kdtree (DONE->NODES).
//  load_kdtree while busy: ignored, load_err pulses next cycle, and no state or counter changes.
//  load_kdtree and an accepted word in the same cycle in IDLE/DONE: impossible by construction, since deq=0 there.
//  Reset (async, any time, including mid-load): state IDLE; all counters 0.
//    All outputs 0: wen strobes, addrs, data, busy, load_done, load_err.
//    A partially assembled item is discarded; the FIFO contents are not flushed.
//  No arithmetic beyond counters. leaf_widx = in word[IDX_WIDTH-1:0]; upper bits are ignored.
// CONFIGURATION
//  KDLOAD_QUERY_RELOAD_EN
//    defined: adds input port load_queries (1-cycle pulse).
//      Accepted in IDLE or DONE: jumps directly to QUERIES (query count 0), clears load_done, keeps the tree.
//      Lets a new image frame be loaded without resending the tree.
//      While busy: ignored, with load_err as above. Simultaneous with load_kdtree: load_kdtree wins.
//    undefined: port absent; QUERIES is reachable only from LEAVES.
// TESTING
//  T1 full load: pulse, then 126+3072+2470 words with no gaps.
//     -> 63 node_wen (addr 0..62), 512 leaf_wen (leaf 0..63 x slot 0..7), 494 query_wen (addr 0..493).
//     -> load_done=1 one cycle after the last word; busy=0.
//  T2 packing: node words 2,517 -> node_wdim=2, node_wmedian=517.
//     Leaf words 1,2,3,4,5,300 -> leaf_wpatch={5,4,3,2,1}, leaf_widx=300, leaf 0 slot 0.
//  T3 backpressure: in_fifo_rempty_n toggled randomly at 50% during T1.
//     -> identical write sequence and contents; deq never high while rempty_n=0.
//  T4 rst=1 asynchronously mid-LEAVES (after leaf 10 slot 3 word 2).
//     -> all outputs 0 immediately; a new pulse plus a full stream reproduces T1.
//  T5 load_kdtree pulsed during NODES -> load_err=1 for 1 cycle; node addresses continue unbroken.
//  T6 (KDLOAD_QUERY_RELOAD_EN) after T1, pulse load_queries and send 2470 words.
//     -> 494 query_wen and no node/leaf writes; load_done re-asserts.

Source files
------------

// File: rtl/kdtree_load_if.sv
// rtl/kdtree_load_if.sv - FIFO read side and KD-tree storage write ports of the load sequencer
// KDLOAD_QUERY_RELOAD_EN adds the load_queries start pulse.
interface kdtree_load_if #(
  parameter int DATA_WIDTH  = 11,
  parameter int IDX_WIDTH   = 9,
  parameter int PATCH_SIZE  = 5,
  parameter int LEAF_SIZE   = 8,
  parameter int LEAF_ADDRW  = 6,
  parameter int QUERY_ADDRW = 9
) ();
  logic                             load_kdtree;
`ifdef KDLOAD_QUERY_RELOAD_EN
  logic                             load_queries;
`endif
  logic [DATA_WIDTH-1:0]            in_fifo_rdata;
  logic                             in_fifo_rempty_n;
  logic                             in_fifo_deq;
  logic                             node_wen;
  logic [LEAF_ADDRW-1:0]            node_waddr;
  logic [DATA_WIDTH-1:0]            node_wdim;
  logic [DATA_WIDTH-1:0]            node_wmedian;
  logic                             leaf_wen;
  logic [LEAF_ADDRW-1:0]            leaf_waddr;
  logic [$clog2(LEAF_SIZE)-1:0]     leaf_wslot;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wpatch;
  logic [IDX_WIDTH-1:0]             leaf_widx;
  logic                             query_wen;
  logic [QUERY_ADDRW-1:0]           query_waddr;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wpatch;
  logic                             busy;
  logic                             load_done;
  logic                             load_err;

  modport master (
`ifdef KDLOAD_QUERY_RELOAD_EN
    output load_queries,
`endif
    output load_kdtree, in_fifo_rdata, in_fifo_rempty_n,
    input  in_fifo_deq, node_wen, node_waddr, node_wdim, node_wmedian,
    input  leaf_wen, leaf_waddr, leaf_wslot, leaf_wpatch, leaf_widx,
    input  query_wen, query_waddr, query_wpatch, busy, load_done, load_err
  );

  modport slave (
`ifdef KDLOAD_QUERY_RELOAD_EN
    input  load_queries,
`endif
    input  load_kdtree, in_fifo_rdata, in_fifo_rempty_n,
    output in_fifo_deq, node_wen, node_waddr, node_wdim, node_wmedian,
    output leaf_wen, leaf_waddr, leaf_wslot, leaf_wpatch, leaf_widx,
    output query_wen, query_waddr, query_wpatch, busy, load_done, load_err
  );
endinterface

// File: rtl/kdtree_load_ctrl.sv
// rtl/kdtree_load_ctrl.sv - drains the input FIFO into KD-tree node, leaf and query memories
// KDLOAD_QUERY_RELOAD_EN: load_queries restarts at QUERIES from IDLE/DONE, keeping the tree.
module kdtree_load_ctrl #(
  parameter int DATA_WIDTH  = 11,
  parameter int IDX_WIDTH   = 9,
  parameter int PATCH_SIZE  = 5,
  parameter int LEAF_SIZE   = 8,
  parameter int NUM_LEAVES  = 64,
  parameter int NUM_QUERYS  = 494,
  parameter int LEAF_ADDRW  = 6,
  parameter int QUERY_ADDRW = 9
) (
  input  logic         clk,
  input  logic         rst,
  kdtree_load_if.slave io
);
  localparam int NUM_NODES = NUM_LEAVES - 1;
  localparam int SLOTW     = $clog2(LEAF_SIZE);
  localparam int WCW       = $clog2(PATCH_SIZE + 1);
  localparam int PW        = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_NODES, S_LEAVES, S_QUERIES, S_DONE} state_t;

  state_t                 state, state_next;
  logic [WCW-1:0]         word_cnt;
  logic [QUERY_ADDRW-1:0] item_cnt;
  logic [SLOTW-1:0]       slot_cnt;
  logic [PW-1:0]          shift_buf;
  logic busy_w, accept, start_tree, start_query, req_any;
  logic node_end, leaf_end, query_end, item_end, slot_wrap, phase_end;

  always_comb begin
    busy_w      = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERIES);
    accept      = busy_w && io.in_fifo_rempty_n;
    start_tree  = !busy_w && io.load_kdtree;
`ifdef KDLOAD_QUERY_RELOAD_EN
    start_query = !busy_w && io.load_queries && !io.load_kdtree;
    req_any     = io.load_kdtree || io.load_queries;
`else
    start_query = 1'b0;
    req_any     = io.load_kdtree;
`endif
    node_end  = (state == S_NODES)   && (word_cnt == WCW'(1));
    leaf_end  = (state == S_LEAVES)  && (word_cnt == WCW'(PATCH_SIZE));
    query_end = (state == S_QUERIES) && (word_cnt == WCW'(PATCH_SIZE - 1));
    item_end  = node_end || leaf_end || query_end;
    slot_wrap = (slot_cnt == SLOTW'(LEAF_SIZE - 1));
    phase_end = (node_end && item_cnt == QUERY_ADDRW'(NUM_NODES - 1))
             || (leaf_end && slot_wrap && item_cnt == QUERY_ADDRW'(NUM_LEAVES - 1))
             || (query_end && item_cnt == QUERY_ADDRW'(NUM_QUERYS - 1));

    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_tree)       state_next = S_NODES;
        else if (start_query) state_next = S_QUERIES;
      end
      S_NODES:   if (accept && phase_end) state_next = S_LEAVES;
      S_LEAVES:  if (accept && phase_end) state_next = S_QUERIES;
      S_QUERIES: if (accept && phase_end) state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign io.in_fifo_deq = accept;
  assign io.busy        = busy_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt        <= '0;
      item_cnt        <= '0;
      slot_cnt        <= '0;
      shift_buf       <= '0;
      io.node_wen     <= 1'b0;
      io.node_waddr   <= '0;
      io.node_wdim    <= '0;
      io.node_wmedian <= '0;
      io.leaf_wen     <= 1'b0;
      io.leaf_waddr   <= '0;
      io.leaf_wslot   <= '0;
      io.leaf_wpatch  <= '0;
      io.leaf_widx    <= '0;
      io.query_wen    <= 1'b0;
      io.query_waddr  <= '0;
      io.query_wpatch <= '0;
      io.load_done    <= 1'b0;
      io.load_err     <= 1'b0;
    end else begin
      io.node_wen  <= 1'b0;
      io.leaf_wen  <= 1'b0;
      io.query_wen <= 1'b0;
      io.load_err  <= busy_w && req_any;
      if (start_tree || start_query) begin
        word_cnt     <= '0;
        item_cnt     <= '0;
        slot_cnt     <= '0;
        io.load_done <= 1'b0;
      end else if (accept) begin
        // Newest word enters at the top so word 0 ends up in the low slice.
        shift_buf <= {io.in_fifo_rdata, shift_buf[PW-1:DATA_WIDTH]};
        if (!item_end) begin
          word_cnt <= word_cnt + WCW'(1);
        end else begin
          word_cnt <= '0;
          if (phase_end) begin
            item_cnt <= '0;
            slot_cnt <= '0;
          end else if (state == S_LEAVES) begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOTW'(1);
            if (slot_wrap) item_cnt <= item_cnt + QUERY_ADDRW'(1);
          end else begin
            item_cnt <= item_cnt + QUERY_ADDRW'(1);
          end
        end
        if (node_end) begin
          io.node_wen     <= 1'b1;
          io.node_waddr   <= item_cnt[LEAF_ADDRW-1:0];
          io.node_wdim    <= shift_buf[PW-1 -: DATA_WIDTH];
          io.node_wmedian <= io.in_fifo_rdata;
        end
        if (leaf_end) begin
          io.leaf_wen    <= 1'b1;
          io.leaf_waddr  <= item_cnt[LEAF_ADDRW-1:0];
          io.leaf_wslot  <= slot_cnt;
          io.leaf_wpatch <= shift_buf;
          io.leaf_widx   <= io.in_fifo_rdata[IDX_WIDTH-1:0];
        end
        if (query_end) begin
          io.query_wen    <= 1'b1;
          io.query_waddr  <= item_cnt;
          io.query_wpatch <= {io.in_fifo_rdata, shift_buf[PW-1:DATA_WIDTH]};
        end
        if (query_end && phase_end) io.load_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// tb/tb_kdtree_load_ctrl.sv - scoreboard bench for kdtree_load_ctrl with random FIFO traffic
module tb_kdtree_load_ctrl;
  localparam int DW = 11, IW = 9, PS = 5, LS = 8, NL = 64, NQ = 494, NN = NL - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kdtree_load_if bus ();
  kdtree_load_ctrl dut (.clk(clk), .rst(rst), .io(bus));

  typedef struct {
    int            kind;
    int            addr;
    int            slot;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [PS*DW-1:0] patch;
    logic [IW-1:0] idx;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] stream[$];
  int n_cmp = 0, n_err = 0;
  int n_node = 0, n_leaf = 0, n_query = 0, deq_viol = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  task automatic build(input bit tree, input bit fixed);
    logic [DW-1:0] w[6];
    exp_t e;
    stream.delete();
    if (tree) begin
      for (int n = 0; n < NN; n++) begin
        w[0] = (fixed && n == 0) ? DW'(2)   : rnd_word();
        w[1] = (fixed && n == 0) ? DW'(517) : rnd_word();
        stream.push_back(w[0]); stream.push_back(w[1]);
        e = '{default: 0};
        e.kind = 0; e.addr = n; e.d0 = w[0]; e.d1 = w[1];
        exp_q.push_back(e);
      end
      for (int l = 0; l < NL; l++)
        for (int s = 0; s < LS; s++) begin
          e = '{default: 0};
          for (int k = 0; k < 6; k++) begin
            w[k] = rnd_word();
            if (fixed && l == 0 && s == 0) w[k] = (k == 5) ? DW'(300) : DW'(k + 1);
            stream.push_back(w[k]);
            if (k < PS) e.patch[k*DW +: DW] = w[k];
          end
          e.kind = 1; e.addr = l; e.slot = s; e.idx = w[5][IW-1:0];
          exp_q.push_back(e);
        end
    end
    for (int q = 0; q < NQ; q++) begin
      e = '{default: 0};
      for (int k = 0; k < PS; k++) begin
        w[k] = rnd_word();
        stream.push_back(w[k]);
        e.patch[k*DW +: DW] = w[k];
      end
      e.kind = 2; e.addr = q; e.last = (q == NQ - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int count, input int gap_pct);
    int i = 0;
    int cyc = 0;
    while (i < count && cyc < 40000) begin
      @(posedge clk); #1;
      bus.in_fifo_rempty_n = ($urandom_range(0, 99) >= gap_pct);
      bus.in_fifo_rdata    = stream[i];
      @(negedge clk);
      if (bus.in_fifo_deq) i++;
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_fifo_rempty_n = 1'b0;
    if (i < count) chk("send_timeout", 64'(i), 64'(count));
  endtask

  task automatic pulse_load();
    @(posedge clk); #1 bus.load_kdtree = 1'b1;
    @(posedge clk); #1 bus.load_kdtree = 1'b0;
  endtask

  task automatic drain_and_check(input int en, input int el, input int eq);
    int c = 0;
    while (exp_q.size() > 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("node_count", 64'(n_node), 64'(en));
    chk("leaf_count", 64'(n_leaf), 64'(el));
    chk("query_count", 64'(n_query), 64'(eq));
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("done_after", 64'(bus.load_done), 64'd1);
    n_node = 0; n_leaf = 0; n_query = 0;
  endtask

  task automatic check_zero();
    chk("z_busy", 64'(bus.busy), 0);            chk("z_deq", 64'(bus.in_fifo_deq), 0);
    chk("z_node_wen", 64'(bus.node_wen), 0);    chk("z_node_waddr", 64'(bus.node_waddr), 0);
    chk("z_node_wdim", 64'(bus.node_wdim), 0);  chk("z_node_wmedian", 64'(bus.node_wmedian), 0);
    chk("z_leaf_wen", 64'(bus.leaf_wen), 0);    chk("z_leaf_waddr", 64'(bus.leaf_waddr), 0);
    chk("z_leaf_wslot", 64'(bus.leaf_wslot), 0); chk("z_leaf_wpatch", 64'(bus.leaf_wpatch), 0);
    chk("z_leaf_widx", 64'(bus.leaf_widx), 0);  chk("z_query_wen", 64'(bus.query_wen), 0);
    chk("z_query_waddr", 64'(bus.query_waddr), 0); chk("z_query_wpatch", 64'(bus.query_wpatch), 0);
    chk("z_load_done", 64'(bus.load_done), 0);  chk("z_load_err", 64'(bus.load_err), 0);
  endtask

  // Monitor: pops one expected write whenever any strobe appears.
  exp_t m_e;
  int   m_nw;
  int   m_kind;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_fifo_deq && !bus.in_fifo_rempty_n) deq_viol++;
      m_nw = int'(bus.node_wen) + int'(bus.leaf_wen) + int'(bus.query_wen);
      if (m_nw != 0) begin
        chk("exclusive_wen", 64'(m_nw), 64'd1);
        m_kind = bus.node_wen ? 0 : (bus.leaf_wen ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(m_kind + 1), 64'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("write_kind", 64'(m_kind), 64'(m_e.kind));
          if (m_kind == 0) begin
            chk("node_waddr", 64'(bus.node_waddr), 64'(m_e.addr));
            chk("node_wdim", 64'(bus.node_wdim), 64'(m_e.d0));
            chk("node_wmedian", 64'(bus.node_wmedian), 64'(m_e.d1));
            n_node++;
          end else if (m_kind == 1) begin
            chk("leaf_waddr", 64'(bus.leaf_waddr), 64'(m_e.addr));
            chk("leaf_wslot", 64'(bus.leaf_wslot), 64'(m_e.slot));
            chk("leaf_wpatch", 64'(bus.leaf_wpatch), 64'(m_e.patch));
            chk("leaf_widx", 64'(bus.leaf_widx), 64'(m_e.idx));
            n_leaf++;
          end else begin
            chk("query_waddr", 64'(bus.query_waddr), 64'(m_e.addr));
            chk("query_wpatch", 64'(bus.query_wpatch), 64'(m_e.patch));
            n_query++;
          end
          chk("load_done_timing", 64'(bus.load_done), 64'(m_e.last));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.load_kdtree      = 1'b0;
    bus.in_fifo_rempty_n = 1'b0;
    bus.in_fifo_rdata    = '0;
`ifdef KDLOAD_QUERY_RELOAD_EN
    bus.load_queries     = 1'b0;
`endif
    #12 check_zero();
    @(posedge clk); #2 rst = 1'b0;

    // T1/T2: full load without gaps, first node and leaf carry known words
    build(1'b1, 1'b1);
    pulse_load();
    chk("busy_started", 64'(bus.busy), 64'd1);
    chk("done_clear", 64'(bus.load_done), 64'd0);
    send(stream.size(), 0);
    drain_and_check(NN, NL * LS, NQ);

    // T3: 50% FIFO stalls
    build(1'b1, 1'b0);
    pulse_load();
    chk("done_clear_t3", 64'(bus.load_done), 64'd0);
    send(stream.size(), 50);
    drain_and_check(NN, NL * LS, NQ);

    // T4: async reset after leaf 10 slot 3 word 2, then a clean reload
    build(1'b1, 1'b0);
    pulse_load();
    send(2 * NN + 10 * LS * 6 + 3 * 6 + 3, 30);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero();
    exp_q.delete();
    n_node = 0; n_leaf = 0; n_query = 0;
    @(posedge clk); #2 rst = 1'b0;
    build(1'b1, 1'b0);
    pulse_load();
    send(stream.size(), 0);
    drain_and_check(NN, NL * LS, NQ);

    // T5: load_kdtree while busy in NODES
    build(1'b1, 1'b0);
    pulse_load();
    fork
      send(stream.size(), 0);
      begin
        repeat (30) @(posedge clk);
        #1 bus.load_kdtree = 1'b1;
        @(negedge clk) chk("load_err_before", 64'(bus.load_err), 64'd0);
        @(posedge clk); #1 bus.load_kdtree = 1'b0;
        @(negedge clk) chk("load_err_pulse", 64'(bus.load_err), 64'd1);
        chk("busy_kept", 64'(bus.busy), 64'd1);
        @(negedge clk) chk("load_err_single", 64'(bus.load_err), 64'd0);
      end
    join
    drain_and_check(NN, NL * LS, NQ);

`ifdef KDLOAD_QUERY_RELOAD_EN
    // T6: query-only reload keeps the tree
    build(1'b0, 1'b0);
    @(posedge clk); #1 bus.load_queries = 1'b1;
    @(posedge clk); #1 bus.load_queries = 1'b0;
    chk("qreload_busy", 64'(bus.busy), 64'd1);
    chk("qreload_done_clear", 64'(bus.load_done), 64'd0);
    send(stream.size(), 25);
    drain_and_check(0, 0, NQ);
`endif

    chk("deq_while_empty", 64'(deq_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
